// File: rtl/freq_div.sv
// rtl/freq_div.sv - programmable power-of-two clock divider with glitch-free ratio change
module freq_div (
  input  logic clk,
  input  logic rst_n,
  input  logic EN,
  input  logic prescale_0,
  input  logic prescale_1,
  input  logic prescale_2,
  output logic watch_clk
);

  // Active ratio selection, half-period counter and the divided clock itself.
  logic [2:0] sel_q, sel_d;
  logic [7:0] cnt_q, cnt_d;
  logic       watch_clk_q, watch_clk_d;

  logic [2:0] prescale;
  logic [7:0] half_term;
  logic       at_term;

  assign prescale  = {prescale_2, prescale_1, prescale_0};
  // Terminal count of a half period; 2^7-1 = 127 is the largest and fits in 8 bits.
  assign half_term = (8'd1 << sel_q) - 8'd1;
  assign at_term   = (cnt_q == half_term);

  // Next-state: count half periods; a new ratio is only adopted on the falling
  // toggle so the period in flight always completes at the old ratio.
  always_comb begin
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    watch_clk_d = watch_clk_q;
    if (!EN) begin
      cnt_d       = 8'd0;
      watch_clk_d = 1'b0;
      sel_d       = prescale;
    end else if (at_term) begin
      cnt_d       = 8'd0;
      watch_clk_d = ~watch_clk_q;
      if (watch_clk_q) begin
        sel_d = prescale;
      end
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // State registers; reset clears everything without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= 3'd0;
      cnt_q       <= 8'd0;
      watch_clk_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      watch_clk_q <= watch_clk_d;
    end
  end

  assign watch_clk = watch_clk_q;

endmodule

// File: tb/tb_freq_div.sv
// tb/tb_freq_div.sv - directed self-checking bench for freq_div
module tb_freq_div;

  logic clk;
  logic rst_n;
  logic en;
  logic p0, p1, p2;
  logic watch_clk;

  int passed;
  int total;

  freq_div dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .EN         (en),
    .prescale_0 (p0),
    .prescale_1 (p1),
    .prescale_2 (p2),
    .watch_clk  (watch_clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_p(input int p);
    {p2, p1, p0} = p[2:0];
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until watch_clk reaches the given level (limit+1 on timeout).
  task automatic count_until(input logic level, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (watch_clk !== level && n <= limit);
  endtask

  // Hold EN low for one edge with prescale p, then enable.
  task automatic restart(input int p);
    en = 1'b0;
    set_p(p);
    tick();
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    set_p(0);
    #3;
    total++;
    if (watch_clk !== 1'b0 || dut.cnt_q !== 8'd0 || dut.sel_q !== 3'd0)
      $display("FAIL reset_state: watch_clk=%b cnt=%0d sel=%0d, required 0/0/0", watch_clk, dut.cnt_q, dut.sel_q);
    else passed++;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (watch_clk !== 1'b0)
      $display("FAIL reset_release: watch_clk=%b, required 0", watch_clk);
    else passed++;
  endtask

  task automatic test_first_period();
    int n;
    restart(2);
    count_until(1'b1, 20, n);
    total++;
    if (n !== 4) $display("FAIL p2_first_rise: edge %0d, required 4", n); else passed++;
    count_until(1'b0, 20, n);
    total++;
    if (n !== 4) $display("FAIL p2_first_fall: after %0d more edges (edge %0d), required 4 (edge 8)", n, n + 4); else passed++;
    count_until(1'b1, 20, n);
    total++;
    if (n !== 4) $display("FAIL p2_low_time: %0d, required 4", n); else passed++;
    count_until(1'b0, 20, n);
    total++;
    if (n !== 4) $display("FAIL p2_high_time: %0d, required 4", n); else passed++;
  endtask

  task automatic test_extremes();
    int n;
    restart(0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (watch_clk !== logic'(k & 1))
        $display("FAIL p0_toggle edge %0d: watch_clk=%b, required %b", k, watch_clk, logic'(k & 1));
      else passed++;
    end
    restart(7);
    count_until(1'b1, 300, n);
    total++;
    if (n !== 128) $display("FAIL p7_first_rise: edge %0d, required 128", n); else passed++;
    count_until(1'b0, 300, n);
    total++;
    if (n !== 128) $display("FAIL p7_high_time: %0d, required 128", n); else passed++;
    count_until(1'b1, 300, n);
    total++;
    if (n !== 128) $display("FAIL p7_low_time: %0d, required 128", n); else passed++;
  endtask

  task automatic test_prescale_change();
    int n;
    restart(1);
    count_until(1'b1, 20, n);
    total++;
    if (n !== 2) $display("FAIL chg_first_rise: edge %0d, required 2", n); else passed++;
    set_p(3);
    count_until(1'b0, 20, n);
    total++;
    if (n !== 2) $display("FAIL chg_old_period_fall: edge %0d, required 4", n + 2); else passed++;
    count_until(1'b1, 40, n);
    total++;
    if (n !== 8) $display("FAIL chg_new_low: %0d, required 8", n); else passed++;
    count_until(1'b0, 40, n);
    total++;
    if (n !== 8) $display("FAIL chg_new_high: %0d, required 8", n); else passed++;
  endtask

  task automatic test_en_drop();
    int n;
    restart(2);
    count_until(1'b1, 20, n);
    tick();
    tick();
    total++;
    if (watch_clk !== 1'b1 || dut.cnt_q !== 8'd2)
      $display("FAIL drop_setup: watch_clk=%b cnt=%0d, required 1/2", watch_clk, dut.cnt_q);
    else passed++;
    en = 1'b0;
    tick();
    total++;
    if (watch_clk !== 1'b0) $display("FAIL drop_low: watch_clk=%b, required 0", watch_clk); else passed++;
    en = 1'b1;
    count_until(1'b1, 20, n);
    total++;
    if (n !== 4) $display("FAIL drop_resume_rise: edge %0d, required 4", n); else passed++;
  endtask

  task automatic test_async_reset();
    int n;
    restart(2);
    count_until(1'b1, 20, n);
    tick();
    total++;
    if (watch_clk !== 1'b1) $display("FAIL arst_setup: watch_clk=%b, required 1", watch_clk); else passed++;
    rst_n = 1'b0;
    #2;
    total++;
    if (watch_clk !== 1'b0 || dut.cnt_q !== 8'd0 || dut.sel_q !== 3'd0)
      $display("FAIL arst_immediate: watch_clk=%b cnt=%0d sel=%0d, required 0/0/0", watch_clk, dut.cnt_q, dut.sel_q);
    else passed++;
    en = 1'b0;
    set_p(2);
    #2;
    rst_n = 1'b1;
    tick();
    en = 1'b1;
    count_until(1'b1, 20, n);
    total++;
    if (n !== 4) $display("FAIL arst_resume_rise: edge %0d, required 4", n); else passed++;
  endtask

  task automatic test_sweep();
    int n;
    int len;
    int bad;
    int runs;
    int rises;
    logic prev;
    restart(0);
    for (int p = 0; p < 8; p++) begin
      set_p(p);
      // The next falling toggle is where the new ratio takes over.
      n = 0;
      prev = watch_clk;
      do begin
        prev = watch_clk;
        tick();
        n++;
      end while (!(prev === 1'b1 && watch_clk === 1'b0) && n <= 600);
      total++;
      if (n > 600) begin
        $display("FAIL sweep_p%0d_sync: no falling edge within 600 cycles", p);
        continue;
      end else passed++;
      len = 1;
      bad = 0;
      runs = 0;
      rises = 0;
      prev = watch_clk;
      for (int k = 0; k < 1024; k++) begin
        tick();
        if (watch_clk === prev) begin
          len++;
        end else begin
          if (len != (1 << p)) bad++;
          runs++;
          if (watch_clk === 1'b1) rises++;
          len = 1;
        end
        prev = watch_clk;
      end
      total++;
      if (bad !== 0) $display("FAIL sweep_p%0d_pulse: %0d pulses not %0d long", p, bad, 1 << p); else passed++;
      total++;
      if (runs !== (1024 >> p)) $display("FAIL sweep_p%0d_edges: %0d toggles, required %0d", p, runs, 1024 >> p); else passed++;
      total++;
      if (rises !== (512 >> p)) $display("FAIL sweep_p%0d_periods: %0d rises, required %0d", p, rises, 512 >> p); else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    set_p(0);
    test_reset();
    test_first_period();
    test_extremes();
    test_prescale_change();
    test_en_drop();
    test_async_reset();
    test_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/freq_div.md
FREQ_DIV -- requirements
Module: freq_div

Interface
REQ-001 The block SHALL have exactly one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 The `clk` port SHALL be an input, 1 bit wide, and SHALL be the single clock; all state SHALL update on its rising edge only.
REQ-003 The `rst_n` port SHALL be an input, 1 bit wide, and SHALL be the asynchronous active-low reset.
REQ-004 The `EN` port SHALL be an input, 1 bit wide; 1 = divider runs, 0 = divider held idle.
REQ-005 The `prescale_0` port SHALL be an input, 1 bit wide, and SHALL be the prescale code bit 0 (LSB).
REQ-006 The `prescale_1` port SHALL be an input, 1 bit wide, and SHALL be the prescale code bit 1.
REQ-007 The `prescale_2` port SHALL be an input, 1 bit wide, and SHALL be the prescale code bit 2 (MSB).
REQ-008 The `watch_clk` port SHALL be an output, 1 bit wide, and SHALL be the divided clock, driven directly from a flip-flop with no combinational path from any input.

Function
REQ-009 The prescale code P SHALL be {prescale_2, prescale_1, prescale_0}, unsigned, 0..7.
REQ-010 The division ratio SHALL be N = 2^(P+1), i.e. 2, 4, 8, ..., 256 clk cycles per watch_clk period, with 50% duty cycle.
REQ-011 The block SHALL hold an active selection register SEL (3 bits), an 8-bit half-period counter CNT and a watch_clk register.
REQ-012 The half-period terminal value SHALL be H = 2^SEL - 1; CNT width SHALL hold H = 127 without overflow.
REQ-013 On a clk edge with EN=1 and CNT != H, the block SHALL set CNT to CNT+1, with watch_clk unchanged.
REQ-014 On a clk edge with EN=1 and CNT == H, the block SHALL set CNT to 0 and invert watch_clk.
REQ-015 When SEL=0, H SHALL be 0 and watch_clk SHALL toggle on every enabled edge (divide by 2).
REQ-016 SEL SHALL load P only at a clk edge where EN=1, CNT == H and watch_clk == 1 (end of a full period, falling toggle); otherwise SEL SHALL hold.
REQ-017 On a clk edge with EN=0, the block SHALL set CNT to 0 and watch_clk to 0, and SHALL load P into SEL every cycle.
REQ-018 A prescale change while running SHALL never produce a truncated or runt pulse; the current period SHALL complete at the old ratio.
REQ-019 When EN rises, the first watch_clk rising edge SHALL occur on the (2^SEL)-th enabled clk edge, counting the first edge with EN=1 as edge 1.
REQ-020 When EN falls mid-period, watch_clk SHALL go low at the next clk edge, and resuming SHALL restart from CNT=0.
REQ-021 CNT SHALL never exceed H, and no wrap-around of CNT SHALL occur under any input sequence.

Reset
REQ-022 Asserting rst_n=0 SHALL immediately, without waiting for clk, force CNT=0, watch_clk=0 and SEL=0.
REQ-023 Reset asserted mid-operation SHALL abandon the current period, and after deassertion the block SHALL behave per REQ-017/REQ-019.
REQ-024 Deassertion of rst_n SHALL take effect on the first clk rising edge after release; no output glitch SHALL occur at release.

Verification
REQ-025 A bench SHALL apply reset, then set EN=0 with P=2 for 1 cycle, then EN=1, and SHALL require: watch_clk rises on the 4th edge, falls on the 8th, with period 8 clk and 4 high / 4 low.
REQ-026 A bench SHALL run P=0 with EN=1, and SHALL require watch_clk to toggle on every clk edge (period 2); with P=7, period 256 and 128 high.
REQ-027 A bench SHALL run P=1, change P to 3 while watch_clk=1 mid-half-period, and SHALL require: the current period finishes at 4 clk, and the next period is 16 clk (8 high / 8 low).
REQ-028 A bench SHALL run P=2 and drop EN while watch_clk=1 with CNT=2, and SHALL require: watch_clk=0 at the next edge; on re-enable, the first rise is 4 edges later.
REQ-029 A bench SHALL assert rst_n=0 between clk edges while watch_clk=1, and SHALL require watch_clk=0 before the next clk edge, with CNT=0 and SEL=0.
REQ-030 A bench SHALL sweep P=0..7 with EN held 1 for 1024 cycles each (changing P at full-period boundaries), and SHALL require: the measured period equals 2^(P+1), duty is exactly 50%, and no pulse is shorter than 2^SEL clk.
